// File: rtl/delay_scale_pkg.sv
// Shared types and helpers for the multi-tap delay-and-scale stage.
package delay_scale_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Gain word value that represents 1.0 for a given number of fraction bits.
    function automatic int unity_gain(input int frac);
        return 1 << frac;
    endfunction

    // Reduce a wide signed value to w bits: clamp when sat is set, otherwise wrap.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] x,
                                                     input int unsigned       w,
                                                     input logic              sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (sat) begin
            if (x > hi)
                res = hi;
            else if (x < lo)
                res = lo;
            else
                res = x;
        end else begin
            res = (x <<< (64 - w)) >>> (64 - w);
        end
        return res;
    endfunction

endpackage

// File: rtl/history_ram.sv
// Sample history store: one write port, one registered read port, no reset so it maps to block RAM.
module history_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clk_in) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk_in) begin
        if (rd_en)
            rd_data_reg <= mem[rd_addr];
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/delay_scale_taps.sv
// Multi-tap delay-and-scale stage: weighted sum of TAPS delayed copies per accepted sample.
// Output reduction clamps when DELAY_SCALE_SATURATE_EN is defined, otherwise wraps.
module delay_scale_taps
    import delay_scale_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 256,
    parameter int TAPS       = 4,
    parameter int SCALE_W    = 8,
    parameter int SCALE_FRAC = 6
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic                             ready_in,
    input  logic signed [WIDTH-1:0]          signal_in,
    input  logic [TAPS*$clog2(DEPTH)-1:0]    delay_in,
    input  logic [TAPS*SCALE_W-1:0]          scale_in,
    output logic signed [WIDTH-1:0]          signal_out,
    output logic                             done_out,
    output logic                             busy_out,
    output logic                             overrun_out
);

    localparam int AW   = $clog2(DEPTH);
    localparam int FW   = AW + 1;
    localparam int PW   = WIDTH + SCALE_W;
    localparam int ACCW = PW + $clog2(TAPS + 1);
    localparam int TW   = (TAPS > 1) ? $clog2(TAPS) : 1;

`ifdef DELAY_SCALE_SATURATE_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    state_t                     state_reg;
    logic [AW-1:0]              wr_ptr_reg;
    logic [AW-1:0]              ptr_latched_reg;
    logic [FW-1:0]              fill_reg;
    logic [TAPS*AW-1:0]         delay_reg;
    logic [TAPS*SCALE_W-1:0]    scale_reg;
    logic [TW-1:0]              tap_reg;
    logic                       mac_valid_reg;
    logic                       gate_reg;
    logic signed [SCALE_W-1:0]  mac_scale_reg;
    logic signed [ACCW-1:0]     acc_reg;
    logic signed [WIDTH-1:0]    signal_reg;
    logic                       done_reg;
    logic                       busy_reg;
    logic                       overrun_reg;

    logic [AW-1:0]              tap_delay [TAPS];
    logic signed [SCALE_W-1:0]  tap_scale [TAPS];

    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_unpack
            assign tap_delay[gi] = delay_reg[gi*AW +: AW];
            assign tap_scale[gi] = scale_reg[gi*SCALE_W +: SCALE_W];
        end
    endgenerate

    logic                       accept;
    logic                       rd_en;
    logic [AW-1:0]              rd_addr;
    logic [WIDTH-1:0]           rd_data;
    logic signed [WIDTH-1:0]    rd_data_s;

    assign accept  = ready_in && (state_reg == ST_IDLE);
    assign rd_en   = (state_reg == ST_READ);
    assign rd_addr = ptr_latched_reg - tap_delay[tap_reg];

    history_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_history_ram (
        .clk_in  (clk_in),
        .wr_en   (accept),
        .wr_addr (wr_ptr_reg),
        .wr_data (signal_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign rd_data_s = $signed(rd_data);

    // Product of the tap whose read was issued last cycle; gated taps add zero.
    logic signed [PW-1:0]       prod;
    logic signed [ACCW-1:0]     mac_term;
    logic signed [ACCW-1:0]     sum_final;
    logic signed [ACCW-1:0]     shifted;
    logic signed [63:0]         res_wide;

    assign prod      = PW'(rd_data_s) * PW'(mac_scale_reg);
    assign mac_term  = (mac_valid_reg && gate_reg) ? ACCW'(prod) : '0;
    assign sum_final = acc_reg + mac_term;
    assign shifted   = sum_final >>> SCALE_FRAC;
    assign res_wide  = sat_trunc(64'(shifted), WIDTH, SAT_EN);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg       <= ST_IDLE;
            wr_ptr_reg      <= '0;
            ptr_latched_reg <= '0;
            fill_reg        <= '0;
            delay_reg       <= '0;
            scale_reg       <= '0;
            tap_reg         <= '0;
            mac_valid_reg   <= 1'b0;
            gate_reg        <= 1'b0;
            mac_scale_reg   <= '0;
            acc_reg         <= '0;
            signal_reg      <= '0;
            done_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            done_reg      <= 1'b0;
            mac_valid_reg <= 1'b0;
            overrun_reg   <= ready_in && (state_reg != ST_IDLE);
            case (state_reg)
                ST_IDLE: begin
                    busy_reg <= 1'b0;
                    if (ready_in) begin
                        ptr_latched_reg <= wr_ptr_reg;
                        wr_ptr_reg      <= wr_ptr_reg + AW'(1);
                        if (fill_reg != FW'(DEPTH))
                            fill_reg <= fill_reg + FW'(1);
                        delay_reg <= delay_in;
                        scale_reg <= scale_in;
                        acc_reg   <= '0;
                        tap_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_READ;
                    end
                end
                ST_READ: begin
                    acc_reg       <= sum_final;
                    // fill_reg already counts the sample just written
                    gate_reg      <= ({1'b0, tap_delay[tap_reg]} < fill_reg);
                    mac_scale_reg <= tap_scale[tap_reg];
                    mac_valid_reg <= 1'b1;
                    if (tap_reg == TW'(TAPS - 1))
                        state_reg <= ST_DRAIN;
                    else
                        tap_reg <= tap_reg + TW'(1);
                end
                ST_DRAIN: begin
                    signal_reg <= res_wide[WIDTH-1:0];
                    done_reg   <= 1'b1;
                    state_reg  <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign signal_out  = signal_reg;
    assign done_out    = done_reg;
    assign busy_out    = busy_reg;
    assign overrun_out = overrun_reg;

endmodule

// File: tb/tb_delay_scale_taps.sv
// Self-checking bench for delay_scale_taps: per-cycle compare against a sample-history model.
module tb_delay_scale_taps;
    import delay_scale_pkg::*;

    localparam int WIDTH      = 16;
    localparam int DEPTH      = 16;
    localparam int TAPS       = 2;
    localparam int SCALE_W    = 8;
    localparam int SCALE_FRAC = 6;
    localparam int AW         = 4;
    localparam int LAT        = TAPS + 2;
    localparam int MAXCYC     = 20000;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       ready = 1'b0;
    logic signed [WIDTH-1:0]    sig_in = '0;
    logic [TAPS*AW-1:0]         delay_in = '0;
    logic [TAPS*SCALE_W-1:0]    scale_in = '0;
    logic signed [WIDTH-1:0]    sig_out;
    logic                       done;
    logic                       busy;
    logic                       ovr;

    always #5 clk = ~clk;

    delay_scale_taps #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .TAPS       (TAPS),
        .SCALE_W    (SCALE_W),
        .SCALE_FRAC (SCALE_FRAC)
    ) dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .ready_in    (ready),
        .signal_in   (sig_in),
        .delay_in    (delay_in),
        .scale_in    (scale_in),
        .signal_out  (sig_out),
        .done_out    (done),
        .busy_out    (busy),
        .overrun_out (ovr)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected per-cycle behaviour, indexed by cycle number
    bit done_map [MAXCYC];
    bit busy_map [MAXCYC];
    bit ovr_map  [MAXCYC];
    int val_map  [MAXCYC];
    int exp_sig  = 0;
    int hist[$];
    int last_due = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Output from the accepted-sample history: delay d picks the sample d strobes back.
    function automatic int model_out(input int d0, input int d1, input int g0, input int g1);
        longint acc;
        longint sh;
        int n;
        acc = 0;
        n = hist.size();
        if (d0 < n) acc += longint'(hist[n-1-d0]) * g0;
        if (d1 < n) acc += longint'(hist[n-1-d1]) * g1;
        sh = acc >>> SCALE_FRAC;
`ifdef DELAY_SCALE_SATURATE_EN
        if (sh > 32767) sh = 32767;
        if (sh < -32768) sh = -32768;
`else
        sh = sh & 64'hFFFF;
        if (sh >= 32768) sh -= 65536;
`endif
        return int'(sh);
    endfunction

    always @(negedge clk) begin
        if (cyc < MAXCYC) begin
            if (done_map[cyc]) exp_sig = val_map[cyc];
            chk("done_out", longint'(done), longint'(done_map[cyc]));
            chk("signal_out", longint'(sig_out), longint'(exp_sig));
            chk("busy_out", longint'(busy), longint'(busy_map[cyc]));
            chk("overrun_out", longint'(ovr), longint'(ovr_map[cyc]));
        end
    end

    task automatic do_reset(input int ncyc);
        @(posedge clk); #2;
        rst_n = 1'b0;
        ready = 1'b0;
        hist.delete();
        exp_sig = 0;
        last_due = 0;
        for (int i = cyc; i < MAXCYC; i++) begin
            done_map[i] = 1'b0;
            busy_map[i] = 1'b0;
            ovr_map[i]  = 1'b0;
        end
        repeat (ncyc) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic send(input int s, input int d0, input int d1, input int g0, input int g1);
        int v;
        @(posedge clk); #2;
        sig_in   = 16'(s);
        delay_in = {4'(d1), 4'(d0)};
        scale_in = {8'(g1), 8'(g0)};
        ready    = 1'b1;
        if (cyc + LAT + 1 >= MAXCYC) begin
            $display("FAIL cycle_budget cyc=%0d got=%0d expected<%0d", cyc, cyc, MAXCYC);
            $fatal(1);
        end
        if (cyc >= last_due) begin
            hist.push_back(s);
            v = model_out(d0, d1, g0, g1);
            val_map[cyc+LAT]  = v;
            done_map[cyc+LAT] = 1'b1;
            for (int i = 1; i <= LAT; i++) busy_map[cyc+i] = 1'b1;
            last_due = cyc + LAT;
        end else begin
            ovr_map[cyc+1] = 1'b1;
        end
        @(posedge clk); #2;
        ready    = 1'b0;
        // Scramble parameters while the computation is in flight
        sig_in   = 16'($urandom);
        delay_in = 8'($urandom);
        scale_in = 16'($urandom);
    endtask

    // Bounded wait for done_out, then compare against a hand-computed value.
    task automatic wait_check(input string name, input int lit, output int lat);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0)
            chk({name, "_timeout"}, 0, 1);
        else
            chk(name, longint'(sig_out), longint'(lit));
    endtask

    initial begin
        int lat;
        int u;
        int echo_exp [5];
        u = unity_gain(SCALE_FRAC);
        echo_exp = '{1000, 0, 0, 500, 0};

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Identity and latency
        do_reset(2);
        send(1000, 0, 0, u, 0);
        wait_check("identity", 1000, lat);
        chk("identity_latency", lat, LAT);

        // Echo
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            send(i == 0 ? 1000 : 0, 0, 3, u, 32);
            wait_check($sformatf("echo_%0d", i), echo_exp[i], lat);
        end

        // Fill gating straight after reset
        do_reset(2);
        for (int i = 0; i < 7; i++) begin
            send(100, 0, 5, u, u);
            wait_check($sformatf("fill_%0d", i), (i < 5) ? 100 : 200, lat);
        end

        // Wrap-around with a ramp
        do_reset(2);
        for (int n = 0; n < 40; n++) begin
            send(n, 0, 15, 0, u);
            wait_check($sformatf("wrap_%0d", n), (n >= 15) ? n - 15 : 0, lat);
        end

        // Overflow
        do_reset(2);
        send(30000, 0, 0, u, u);
`ifdef DELAY_SCALE_SATURATE_EN
        wait_check("overflow_pos", 32767, lat);
`else
        wait_check("overflow_pos", -5536, lat);
`endif
        send(-20000, 0, 0, -128, -128);
`ifdef DELAY_SCALE_SATURATE_EN
        wait_check("overflow_neg_gain", 32767, lat);
`else
        wait_check("overflow_neg_gain", 14464, lat);
`endif

        // Overrun: strobe two cycles after acceptance is dropped
        do_reset(2);
        send(100, 0, 1, u, u);
        send(7777, 0, 1, u, u);
        wait_check("overrun_first", 100, lat);
        send(50, 0, 1, u, u);
        wait_check("overrun_next", 150, lat);

        // Reset during READ discards the in-flight result
        send(1000, 0, 1, u, u);
        do_reset(2);
        repeat (8) @(posedge clk);
        #2;
        chk("reset_signal_out", longint'(sig_out), 0);
        chk("reset_busy_out", longint'(busy), 0);

        // Randomised traffic with occasional resets and overruns
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
            repeat ($urandom_range(0, 4)) @(posedge clk);
            send(int'($urandom_range(0, 65535)) - 32768,
                 $urandom_range(0, 15), $urandom_range(0, 15),
                 int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        end
        repeat (10) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(MAXCYC * 10);
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1);
    end

endmodule
